id_ex_stage: RTL and testbench

- Pipeline register plus operand-forwarding and load-use hazard logic between decode and the execute-stage ALU.
- Captures decoded operands and control each cycle.
- Presents ALU-ready src1/src2/ctrl, with EX/MEM and MEM/WB bypasses applied, together with the control fields carried to the memory stage.
- Detects load-use hazards, stalls decode and injects a bubble; supports branch flush and a downstream hold.

---
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Pipeline register between decode and the execute-stage ALU. It holds the
// decoded operands and control, applies EX/MEM and MEM/WB operand bypasses,
// detects load-use hazards (stalls decode and inserts one bubble), and
// supports a branch flush and a downstream hold.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   id_*                     decoded instruction from the decode stage
//   flush_i                  squash the decode instruction (taken branch)
//   hold_i                   downstream busy, freeze the EX stage
//   exmem_* / memwb_*        bypass sources from later stages
//   src1_o, src2_o, ctrl_o   ALU-ready operands and ALU control
//   store_data_o             forwarded rt value for stores
//   rd_o, reg_write_o, mem_read_o, mem_write_o, valid_o
//                            control carried on to the memory stage
//   stall_o                  decode must hold its instruction
//   stall_cnt_o              saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RW  = 5,
  parameter int unsigned CW  = 4,
  parameter int unsigned SCW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          id_valid_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic [RW-1:0] id_rd_i,
  input  logic          id_uses_rt_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic          id_alu_src_i,
  input  logic [CW-1:0] id_ctrl_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic          id_mem_write_i,
  input  logic          flush_i,
  input  logic          hold_i,
  input  logic          exmem_reg_write_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] src1_o,
  output logic [DW-1:0] src2_o,
  output logic [CW-1:0] ctrl_o,
  output logic [DW-1:0] store_data_o,
  output logic [RW-1:0] rd_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          valid_o,
  output logic          stall_o,
  output logic [SCW-1:0] stall_cnt_o
);

  localparam logic [RW-1:0]  REG_ZERO = {RW{1'b0}};
  localparam logic [SCW-1:0] CNT_MAX  = {SCW{1'b1}};
  localparam logic [SCW-1:0] CNT_ONE  = {{(SCW-1){1'b0}}, 1'b1};

  logic          valid_r;
  logic          reg_write_r;
  logic          mem_read_r;
  logic          mem_write_r;
  logic          alu_src_r;
  logic [CW-1:0] ctrl_r;
  logic [RW-1:0] rd_r;
  logic [RW-1:0] rs_r;
  logic [RW-1:0] rt_r;
  logic [DW-1:0] rs_data_r;
  logic [DW-1:0] rt_data_r;
  logic [DW-1:0] imm_r;
  logic [SCW-1:0] stall_cnt_r;

  logic [DW-1:0] fwd_rs_s;
  logic [DW-1:0] fwd_rt_s;
  logic          ex_lu_s;

  // Load in EX whose destination is read by the (unsquashed) decode instruction.
  always_comb begin
    ex_lu_s = 1'b0;
    if (valid_r && mem_read_r && (rd_r != REG_ZERO) && id_valid_i && !flush_i) begin
      ex_lu_s = (id_rs_i == rd_r) || (id_uses_rt_i && (id_rt_i == rd_r));
    end else begin
      ex_lu_s = 1'b0;
    end
  end

  // Operand bypass for rs: EX/MEM wins over MEM/WB, r0 and empty slots never forward.
  always_comb begin
    fwd_rs_s = rs_data_r;
    if (valid_r && exmem_reg_write_i && (exmem_rd_i != REG_ZERO) && (exmem_rd_i == rs_r)) begin
      fwd_rs_s = exmem_result_i;
    end else if (valid_r && memwb_reg_write_i && (memwb_rd_i != REG_ZERO) && (memwb_rd_i == rs_r)) begin
      fwd_rs_s = memwb_data_i;
    end else begin
      fwd_rs_s = rs_data_r;
    end
  end

  // Operand bypass for rt, same priority rules as rs.
  always_comb begin
    fwd_rt_s = rt_data_r;
    if (valid_r && exmem_reg_write_i && (exmem_rd_i != REG_ZERO) && (exmem_rd_i == rt_r)) begin
      fwd_rt_s = exmem_result_i;
    end else if (valid_r && memwb_reg_write_i && (memwb_rd_i != REG_ZERO) && (memwb_rd_i == rt_r)) begin
      fwd_rt_s = memwb_data_i;
    end else begin
      fwd_rt_s = rt_data_r;
    end
  end

  // EX pipeline register: reset > hold > flush > load-use bubble > normal load.
  always_ff @(posedge clk_i) begin
    if (rst_i || (!hold_i && (flush_i || ex_lu_s))) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      alu_src_r   <= 1'b0;
      ctrl_r      <= {CW{1'b0}};
      rd_r        <= REG_ZERO;
      rs_r        <= REG_ZERO;
      rt_r        <= REG_ZERO;
      rs_data_r   <= {DW{1'b0}};
      rt_data_r   <= {DW{1'b0}};
      imm_r       <= {DW{1'b0}};
    end else if (hold_i) begin
      // Capture bypass values now: their producers retire while EX is frozen.
      rs_data_r <= fwd_rs_s;
      rt_data_r <= fwd_rt_s;
    end else begin
      valid_r     <= id_valid_i;
      reg_write_r <= id_valid_i & id_reg_write_i;
      mem_read_r  <= id_valid_i & id_mem_read_i;
      mem_write_r <= id_valid_i & id_mem_write_i;
      alu_src_r   <= id_alu_src_i;
      ctrl_r      <= id_valid_i ? id_ctrl_i : {CW{1'b0}};
      rd_r        <= id_valid_i ? id_rd_i : REG_ZERO;
      rs_r        <= id_rs_i;
      rt_r        <= id_rt_i;
      rs_data_r   <= id_rs_data_i;
      rt_data_r   <= id_rt_data_i;
      imm_r       <= id_imm_i;
    end
  end

  // Saturating count of edges on which a load-use bubble is inserted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= {SCW{1'b0}};
    end else if (ex_lu_s && !hold_i && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_o      = ex_lu_s | hold_i;
  assign stall_cnt_o  = stall_cnt_r;
  assign src1_o       = fwd_rs_s;
  assign src2_o       = alu_src_r ? imm_r : fwd_rt_s;
  assign store_data_o = fwd_rt_s;
  assign ctrl_o       = ctrl_r;
  assign rd_o         = rd_r;
  assign reg_write_o  = reg_write_r;
  assign mem_read_o   = mem_read_r;
  assign mem_write_o  = mem_write_r;
  assign valid_o      = valid_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Table-driven bench for id_ex_stage. Each record holds the inputs driven for
// one cycle and the outputs expected in that same cycle (registered state from
// earlier edges plus combinational forwarding/hazard logic).
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam logic [3:0] C_OR  = 4'd1;
  localparam logic [3:0] C_ADD = 4'd2;
  localparam logic [3:0] C_X5  = 4'd5;
  localparam logic [3:0] C_SUB = 4'd6;
  localparam logic [3:0] C_X7  = 4'd7;

  typedef struct packed {
    logic        rst;
    logic        idv;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        urt;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic        asrc;
    logic [3:0]  ctl;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        fl;
    logic        hd;
    logic        xrw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [31:0] e_s1;
    logic [31:0] e_s2;
    logic [31:0] e_sd;
    logic [3:0]  e_ctl;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_mr;
    logic        e_mw;
    logic        e_vld;
    logic        e_stl;
    logic [15:0] e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        id_uses_rt_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic        id_alu_src_i;
  logic [3:0]  id_ctrl_i;
  logic        id_reg_write_i, id_mem_read_i, id_mem_write_i;
  logic        flush_i, hold_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_result_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_data_i;
  logic [31:0] src1_o, src2_o, store_data_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  rd_o;
  logic        reg_write_o, mem_read_o, mem_write_o, valid_o, stall_o;
  logic [15:0] stall_cnt_o;

  vec_t v;
  vec_t tbl[$];
  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vidx = 0;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_uses_rt_i(id_uses_rt_i), .id_rs_data_i(id_rs_data_i),
    .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_alu_src_i(id_alu_src_i), .id_ctrl_i(id_ctrl_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .id_mem_write_i(id_mem_write_i), .flush_i(flush_i), .hold_i(hold_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o),
    .store_data_o(store_data_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .valid_o(valid_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Decode-slot fields of the record under construction.
  function void idi(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd, input logic urt, input logic [31:0] rsd,
                    input logic [31:0] rtd, input logic [31:0] imm, input logic asrc,
                    input logic [3:0] ctl, input logic rw, input logic mr, input logic mw);
    v.idv = valid; v.rs = rs; v.rt = rt; v.rd = rd; v.urt = urt;
    v.rsd = rsd; v.rtd = rtd; v.imm = imm; v.asrc = asrc; v.ctl = ctl;
    v.rw = rw; v.mr = mr; v.mw = mw;
  endfunction

  // Expected outputs; completes the record and appends it to the table.
  function void xp(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] sd,
                   input logic [3:0] ctl, input logic [4:0] rd, input logic rw,
                   input logic mr, input logic mw, input logic vld, input logic stl,
                   input logic [15:0] cnt);
    v.e_s1 = s1; v.e_s2 = s2; v.e_sd = sd; v.e_ctl = ctl; v.e_rd = rd;
    v.e_rw = rw; v.e_mr = mr; v.e_mw = mw; v.e_vld = vld; v.e_stl = stl; v.e_cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL v%0d %s: got 0x%0h, expected 0x%0h", vidx, nm, act, req);
    end
  endtask

  // Drive one record after the edge, then compare at the falling edge.
  task automatic apply(input vec_t t);
    vec_t e;
    @(posedge clk);
    #1;
    rst_i = t.rst; id_valid_i = t.idv; id_rs_i = t.rs; id_rt_i = t.rt; id_rd_i = t.rd;
    id_uses_rt_i = t.urt; id_rs_data_i = t.rsd; id_rt_data_i = t.rtd; id_imm_i = t.imm;
    id_alu_src_i = t.asrc; id_ctrl_i = t.ctl; id_reg_write_i = t.rw;
    id_mem_read_i = t.mr; id_mem_write_i = t.mw; flush_i = t.fl; hold_i = t.hd;
    exmem_reg_write_i = t.xrw; exmem_rd_i = t.xrd; exmem_result_i = t.xres;
    memwb_reg_write_i = t.wrw; memwb_rd_i = t.wrd; memwb_data_i = t.wdat;
    exp_q.push_back(t);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL v%0d scoreboard: got empty queue, expected an entry", vidx);
    end else begin
      e = exp_q.pop_front();
      chk("src1", src1_o, e.e_s1);
      chk("src2", src2_o, e.e_s2);
      chk("store_data", store_data_o, e.e_sd);
      chk("ctrl", 32'(ctrl_o), 32'(e.e_ctl));
      chk("rd", 32'(rd_o), 32'(e.e_rd));
      chk("reg_write", 32'(reg_write_o), 32'(e.e_rw));
      chk("mem_read", 32'(mem_read_o), 32'(e.e_mr));
      chk("mem_write", 32'(mem_write_o), 32'(e.e_mw));
      chk("valid", 32'(valid_o), 32'(e.e_vld));
      chk("stall", 32'(stall_o), 32'(e.e_stl));
      chk("stall_cnt", 32'(stall_cnt_o), 32'(e.e_cnt));
    end
    vectors++;
    vidx++;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    v = '0;
    apply_idle_reset();

    // Reset held two cycles with a valid decode instruction, then release.
    v = '0; v.rst = 1'b1; idi(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h1111, 32'h2222, 32'h0, 1'b0, C_ADD, 1'b1, 1'b0, 1'b0);
    xp(32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    xp(32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    v.rst = 1'b0;
    xp(32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    // ADDU r3 in EX; SUBU r4<-r3,r5 in decode.
    v = '0; idi(1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 32'hDEAD, 32'h5555, 32'h0, 1'b0, C_SUB, 1'b1, 1'b0, 1'b0);
    xp(32'h1111, 32'h2222, 32'h2222, C_ADD, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    // SUBU in EX, EX/MEM bypass of r3.
    v.xrw = 1'b1; v.xrd = 5'd3; v.xres = 32'h10;
    xp(32'h10, 32'h5555, 32'h5555, C_SUB, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    // Both bypasses match r3: EX/MEM wins.
    v.wrw = 1'b1; v.wrd = 5'd3; v.wdat = 32'h20;
    xp(32'h10, 32'h5555, 32'h5555, C_SUB, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    // MEM/WB only for rs, EX/MEM for rt; LW r7 enters decode.
    v = '0; idi(1'b1, 5'd1, 5'd7, 5'd7, 1'b0, 32'h100, 32'h9999, 32'h4, 1'b1, C_ADD, 1'b1, 1'b1, 1'b0);
    v.wrw = 1'b1; v.wrd = 5'd3; v.wdat = 32'h20; v.xrw = 1'b1; v.xrd = 5'd5; v.xres = 32'h77;
    xp(32'h20, 32'h77, 32'h77, C_SUB, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    // LW r7 in EX, ADDU r8<-r7,r2 in decode: load-use stall.
    v = '0; idi(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 32'h7777, 32'h2222, 32'h0, 1'b0, C_ADD, 1'b1, 1'b0, 1'b0);
    xp(32'h100, 32'h4, 32'h9999, C_ADD, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0);
    // Bubble in EX, decode still holding the ADDU.
    xp(32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    // ADDU in EX, load data bypassed from MEM/WB; LW r0 in decode.
    v = '0; idi(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 32'h100, 32'h0, 32'h8, 1'b1, C_ADD, 1'b1, 1'b1, 1'b0);
    v.wrw = 1'b1; v.wrd = 5'd7; v.wdat = 32'hCAFE_F00D;
    xp(32'hCAFE_F00D, 32'h2222, 32'h2222, C_ADD, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    // LW r0 in EX, use of r0 in decode: no stall.
    v = '0; idi(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, C_ADD, 1'b1, 1'b0, 1'b0);
    xp(32'h100, 32'h8, 32'h0, C_ADD, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    // r0 reader in EX, EX/MEM writes r0: never forwarded.
    v = '0; idi(1'b1, 5'd1, 5'd7, 5'd7, 1'b0, 32'h100, 32'h9999, 32'h4, 1'b1, C_ADD, 1'b1, 1'b1, 1'b0);
    v.xrw = 1'b1; v.xrd = 5'd0; v.xres = 32'hFFFF_FFFF;
    xp(32'h0, 32'h0, 32'h0, C_ADD, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    // LW r7 in EX, rt-use in decode but flushed: no stall, bubble, count kept.
    v = '0; idi(1'b1, 5'd2, 5'd7, 5'd10, 1'b1, 32'h2222, 32'h7777, 32'h0, 1'b0, C_ADD, 1'b1, 1'b0, 1'b0);
    v.fl = 1'b1;
    xp(32'h100, 32'h4, 32'h9999, C_ADD, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    v = '0; idi(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 32'h11, 32'hBAD, 32'h0, 1'b0, C_X5, 1'b1, 1'b0, 1'b0);
    xp(32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    // Hold for three cycles; MEM/WB forwards r2 only in the first.
    v = '0; idi(1'b1, 5'd3, 5'd4, 5'd13, 1'b1, 32'h33, 32'h44, 32'h0, 1'b0, C_X7, 1'b1, 1'b0, 1'b0);
    v.hd = 1'b1; v.wrw = 1'b1; v.wrd = 5'd2; v.wdat = 32'h55;
    xp(32'h11, 32'h55, 32'h55, C_X5, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
    v.wrw = 1'b0; v.wrd = 5'd0; v.wdat = 32'h0;
    xp(32'h11, 32'h55, 32'h55, C_X5, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
    v.fl = 1'b1;
    xp(32'h11, 32'h55, 32'h55, C_X5, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
    v.fl = 1'b0; v.hd = 1'b0;
    xp(32'h11, 32'h55, 32'h55, C_X5, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    // LW r9 then SW reading r9 through rt: stall, then MEM/WB store data.
    v = '0; idi(1'b1, 5'd1, 5'd9, 5'd9, 1'b0, 32'h200, 32'h0, 32'h10, 1'b1, C_ADD, 1'b1, 1'b1, 1'b0);
    xp(32'h33, 32'h44, 32'h44, C_X7, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    v = '0; idi(1'b1, 5'd3, 5'd9, 5'd0, 1'b1, 32'h33, 32'h999, 32'h0, 1'b1, C_ADD, 1'b0, 1'b0, 1'b1);
    xp(32'h200, 32'h10, 32'h0, C_ADD, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1);
    xp(32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    // SW in EX; an invalid decode slot with control bits set follows.
    v = '0; idi(1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 32'h11, 32'h22, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    v.wrw = 1'b1; v.wrd = 5'd9; v.wdat = 32'hABCD;
    xp(32'h33, 32'h0, 32'hABCD, C_ADD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
    // Invalid slot in EX: control cleared, bypass not applied.
    v = '0; v.xrw = 1'b1; v.xrd = 5'd1; v.xres = 32'hF0F0;
    xp(32'h11, 32'h22, 32'h22, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    run_tbl();

    // Reset arriving mid-stall, then an rt match that is not a real operand.
    v = '0; idi(1'b1, 5'd1, 5'd7, 5'd7, 1'b0, 32'h100, 32'h9999, 32'h4, 1'b1, C_ADD, 1'b1, 1'b1, 1'b0);
    xp(32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    v = '0; idi(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 32'h7777, 32'h2222, 32'h0, 1'b0, C_ADD, 1'b1, 1'b0, 1'b0);
    v.rst = 1'b1;
    xp(32'h100, 32'h4, 32'h9999, C_ADD, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2);
    v.rst = 1'b0;
    xp(32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    v = '0; idi(1'b1, 5'd1, 5'd7, 5'd7, 1'b0, 32'h100, 32'h9999, 32'h4, 1'b1, C_ADD, 1'b1, 1'b1, 1'b0);
    xp(32'h7777, 32'h2222, 32'h2222, C_ADD, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    v = '0; idi(1'b1, 5'd1, 5'd7, 5'd11, 1'b0, 32'h11, 32'h77, 32'h0, 1'b0, C_OR, 1'b1, 1'b0, 1'b0);
    xp(32'h100, 32'h4, 32'h9999, C_ADD, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    v = '0;
    xp(32'h11, 32'h77, 32'h77, C_OR, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    run_tbl();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // All inputs idle with reset asserted so the first edge clears the DUT.
  task automatic apply_idle_reset();
    rst_i = 1'b1; id_valid_i = 1'b0; id_rs_i = 5'd0; id_rt_i = 5'd0; id_rd_i = 5'd0;
    id_uses_rt_i = 1'b0; id_rs_data_i = 32'h0; id_rt_data_i = 32'h0; id_imm_i = 32'h0;
    id_alu_src_i = 1'b0; id_ctrl_i = 4'd0; id_reg_write_i = 1'b0; id_mem_read_i = 1'b0;
    id_mem_write_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0; exmem_reg_write_i = 1'b0;
    exmem_rd_i = 5'd0; exmem_result_i = 32'h0; memwb_reg_write_i = 1'b0;
    memwb_rd_i = 5'd0; memwb_data_i = 32'h0;
  endtask

endmodule
